// File: rtl/usb_desc_reader.sv
// EP0 GET_DESCRIPTOR engine: decodes setup requests, reads the descriptor ROM byte-wise
// and streams the data stage as max-packet-sized IN packets with retry and ZLP handling.
module usb_desc_reader #(
    parameter int unsigned EP0_MPS = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bus_reset,
    input  logic        hs_mode,
    input  logic        setup_valid,
    input  logic [7:0]  setup_bmreqtype,
    input  logic [7:0]  setup_breq,
    input  logic [15:0] setup_wvalue,
    input  logic [15:0] setup_wlength,
    input  logic        in_req,
    input  logic        in_ack,
    input  logic        in_retry,
    output logic [15:0] descrom_raddr_o,
    input  logic [7:0]  descrom_rdata_i,
    input  logic [15:0] desc_dev_addr_i,
    input  logic [15:0] desc_dev_len_i,
    input  logic [15:0] desc_qual_addr_i,
    input  logic [15:0] desc_qual_len_i,
    input  logic [15:0] desc_hscfg_addr_i,
    input  logic [15:0] desc_hscfg_len_i,
    input  logic [15:0] desc_fscfg_addr_i,
    input  logic [15:0] desc_fscfg_len_i,
    input  logic [15:0] desc_oscfg_addr_i,
    input  logic [15:0] desc_hidrpt_addr_i,
    input  logic [15:0] desc_hidrpt_len_i,
    input  logic [15:0] desc_bos_addr_i,
    input  logic [15:0] desc_bos_len_i,
    input  logic [15:0] desc_lang_addr_i,
    input  logic [15:0] desc_vendor_addr_i,
    input  logic [15:0] desc_vendor_len_i,
    input  logic [15:0] desc_product_addr_i,
    input  logic [15:0] desc_product_len_i,
    input  logic [15:0] desc_serial_addr_i,
    input  logic [15:0] desc_serial_len_i,
    input  logic        desc_have_strings_i,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        tx_zlp,
    output logic        req_stall,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW = 16;
    localparam logic [AW-1:0] MPS = AW'(EP0_MPS);
    localparam logic [AW-1:0] LANG_LEN = AW'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_SEND,
        S_ZLP,
        S_WAIT_HS
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] start_q, start_d;
    logic [AW-1:0] off_q, off_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [AW-1:0] pkt_len_q, pkt_len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          need_zlp_q, need_zlp_d;
    logic          osc_q, osc_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_last_q, tx_last_d;
    logic          tx_zlp_q, tx_zlp_d;
    logic          req_stall_q, req_stall_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          is_get_c;
    logic          sel_ok_c;
    logic          sel_osc_c;
    logic [AW-1:0] sel_addr_c;
    logic [AW-1:0] sel_len_c;
    logic [AW-1:0] xfer_len_c;
    logic          new_zlp_c;
    logic [AW-1:0] pkt_c;
    logic          keep_zlp_c;

    // Other-speed config reports its bDescriptorType byte from a dedicated ROM location
    function automatic logic [AW-1:0] rom_addr(input logic [AW-1:0] start,
                                               input logic [AW-1:0] off,
                                               input logic          osc,
                                               input logic [AW-1:0] osc_addr);
        return (osc && off == AW'(1)) ? osc_addr : start + off;
    endfunction

    // Descriptor selection from wValue
    always_comb begin
        sel_ok_c   = 1'b1;
        sel_osc_c  = 1'b0;
        sel_addr_c = '0;
        sel_len_c  = '0;
        case (setup_wvalue[15:8])
            8'h01: begin
                sel_addr_c = desc_dev_addr_i;
                sel_len_c  = desc_dev_len_i;
            end
            8'h06: begin
                sel_addr_c = desc_qual_addr_i;
                sel_len_c  = desc_qual_len_i;
            end
            8'h02: begin
                sel_ok_c   = (setup_wvalue[7:0] == 8'h00);
                sel_addr_c = hs_mode ? desc_hscfg_addr_i : desc_fscfg_addr_i;
                sel_len_c  = hs_mode ? desc_hscfg_len_i  : desc_fscfg_len_i;
            end
            8'h07: begin
                sel_ok_c   = (setup_wvalue[7:0] == 8'h00);
                sel_osc_c  = 1'b1;
                sel_addr_c = hs_mode ? desc_fscfg_addr_i : desc_hscfg_addr_i;
                sel_len_c  = hs_mode ? desc_fscfg_len_i  : desc_hscfg_len_i;
            end
            8'h22: begin
                sel_addr_c = desc_hidrpt_addr_i;
                sel_len_c  = desc_hidrpt_len_i;
            end
            8'h0F: begin
                sel_addr_c = desc_bos_addr_i;
                sel_len_c  = desc_bos_len_i;
            end
            8'h03: begin
                sel_ok_c = desc_have_strings_i;
                case (setup_wvalue[7:0])
                    8'h00: begin
                        sel_addr_c = desc_lang_addr_i;
                        sel_len_c  = LANG_LEN;
                    end
                    8'h01: begin
                        sel_addr_c = desc_vendor_addr_i;
                        sel_len_c  = desc_vendor_len_i;
                    end
                    8'h02: begin
                        sel_addr_c = desc_product_addr_i;
                        sel_len_c  = desc_product_len_i;
                    end
                    8'h03: begin
                        sel_addr_c = desc_serial_addr_i;
                        sel_len_c  = desc_serial_len_i;
                    end
                    default: sel_ok_c = 1'b0;
                endcase
            end
            default: sel_ok_c = 1'b0;
        endcase
    end

    assign is_get_c   = (setup_breq == 8'h06) &&
                        ((setup_bmreqtype == 8'h80) || (setup_bmreqtype == 8'h81));
    assign xfer_len_c = (sel_len_c < setup_wlength) ? sel_len_c : setup_wlength;
    assign new_zlp_c  = (xfer_len_c < setup_wlength) && ((xfer_len_c % MPS) == AW'(0));
    assign pkt_c      = (rem_q < MPS) ? rem_q : MPS;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        off_d       = off_q;
        rem_d       = rem_q;
        pkt_len_d   = pkt_len_q;
        idx_d       = idx_q;
        need_zlp_d  = need_zlp_q;
        osc_d       = osc_q;
        raddr_d     = raddr_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        tx_zlp_d    = 1'b0;
        req_stall_d = 1'b0;
        done_d      = 1'b0;
        keep_zlp_c  = 1'b0;

        if (bus_reset) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
        end else if (setup_valid) begin
            // A new setup always abandons whatever transfer was in flight
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            if (is_get_c) begin
                if (!sel_ok_c) begin
                    req_stall_d = 1'b1;
                end else if (setup_wlength == AW'(0)) begin
                    done_d = 1'b1;
                end else begin
                    state_d    = S_WAIT_IN;
                    start_d    = sel_addr_c;
                    off_d      = '0;
                    rem_d      = xfer_len_c;
                    need_zlp_d = new_zlp_c;
                    osc_d      = sel_osc_c;
                end
            end
        end else begin
            case (state_q)
                S_WAIT_IN: begin
                    if (in_req) begin
                        if (rem_q != AW'(0)) begin
                            state_d    = S_SEND;
                            pkt_len_d  = pkt_c;
                            idx_d      = '0;
                            raddr_d    = rom_addr(start_q, off_q, osc_q, desc_oscfg_addr_i);
                            tx_valid_d = 1'b1;
                            tx_last_d  = (pkt_c == AW'(1));
                        end else if (need_zlp_q) begin
                            state_d   = S_ZLP;
                            pkt_len_d = '0;
                            tx_zlp_d  = 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (tx_valid_q && tx_ready) begin
                        if (tx_last_q) begin
                            state_d    = S_WAIT_HS;
                            tx_valid_d = 1'b0;
                            tx_last_d  = 1'b0;
                        end else begin
                            idx_d     = idx_q + AW'(1);
                            raddr_d   = rom_addr(start_q, off_q + idx_q + AW'(1), osc_q,
                                                 desc_oscfg_addr_i);
                            tx_last_d = ((idx_q + AW'(2)) == pkt_len_q);
                        end
                    end
                end
                S_ZLP: begin
                    state_d = S_WAIT_HS;
                end
                S_WAIT_HS: begin
                    if (in_ack) begin
                        off_d      = off_q + pkt_len_q;
                        rem_d      = rem_q - pkt_len_q;
                        keep_zlp_c = need_zlp_q && (pkt_len_q != AW'(0));
                        need_zlp_d = keep_zlp_c;
                        if ((rem_d == AW'(0)) && !keep_zlp_c) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT_IN;
                        end
                    end else if (in_retry) begin
                        state_d = S_WAIT_IN;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            off_q       <= '0;
            rem_q       <= '0;
            pkt_len_q   <= '0;
            idx_q       <= '0;
            need_zlp_q  <= 1'b0;
            osc_q       <= 1'b0;
            raddr_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_zlp_q    <= 1'b0;
            req_stall_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            off_q       <= off_d;
            rem_q       <= rem_d;
            pkt_len_q   <= pkt_len_d;
            idx_q       <= idx_d;
            need_zlp_q  <= need_zlp_d;
            osc_q       <= osc_d;
            raddr_q     <= raddr_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            tx_zlp_q    <= tx_zlp_d;
            req_stall_q <= req_stall_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign descrom_raddr_o = raddr_q;
    assign tx_data         = tx_valid_q ? descrom_rdata_i : 8'h00;
    assign tx_valid        = tx_valid_q;
    assign tx_last         = tx_last_q;
    assign tx_zlp          = tx_zlp_q;
    assign req_stall       = req_stall_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
